// File: rtl/apb_acc_pkg.sv
// Shared types and constants for the accelerator APB initiator.
package apb_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Accelerator register window byte offsets.
    localparam logic [11:0] ACC_REG_0 = 12'h004;
    localparam logic [11:0] ACC_REG_1 = 12'h008;
    localparam logic [11:0] ACC_REG_2 = 12'h00C;
    localparam logic [11:0] ACC_REG_3 = 12'h010;
    localparam logic [11:0] ACC_REG_4 = 12'h014;

    // Wait cycles with PREADY low before a transfer is aborted (0 = never).
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter. expired is raised during the
// wait cycle that brings the count of PREADY-low cycles to TIMEOUT_CYCLES.
module apb_wait_timer
    import apb_acc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);
    localparam logic [CNT_W-1:0] MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Count PREADY-low ACCESS cycles; saturate at MAX so it never wraps.
    always_ff @(posedge HCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!HRESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && count_en && (count >= LAST);

endmodule

// File: rtl/apb_acc_initiator.sv
// APB initiator: one local request becomes one SETUP/ACCESS transfer, and
// the result is parked in RESP until the response handshake completes.
module apb_acc_initiator
    import apb_acc_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]               req_wdata,
    input  logic                      req_write,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    apb_state_e state_q;
    apb_state_e state_d;
    logic       load_req;
    logic       capture_ok;
    logic       capture_abort;
    logic       timer_expired;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clear   (state_q == ST_SETUP),
        .count_en((state_q == ST_ACCESS) && !PREADY),
        .expired (timer_expired)
    );

    // State register; reset drops any transfer in flight without a response.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and bus/handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        load_req      = 1'b0;
        capture_ok    = 1'b0;
        capture_abort = 1'b0;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        PSEL          = 1'b0;
        PENABLE       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = HRESETn;
                if (req_valid) begin
                    load_req = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                PSEL    = 1'b1;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    capture_ok = 1'b1;
                    state_d    = ST_RESP;
                end else if (timer_expired) begin
                    capture_abort = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields drive the bus from SETUP onward; the response is
    // captured once at the end of ACCESS and held through RESP.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (load_req) begin
                PADDR  <= req_addr;
                PWDATA <= req_wdata;
                PWRITE <= req_write;
            end
            if (capture_ok) begin
                rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (capture_abort) begin
                rsp_rdata   <= 32'h0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/apb_acc_initiator.md
# apb_acc_initiator

APB initiator that turns single-word requests on a local valid/ready interface into APB SETUP/ACCESS transfers and returns read data and status on a valid/ready response interface. It drives the peripheral side of the accelerator's APB register window, so the accelerator's operand and result registers can be exercised by an on-chip sequencer or a test harness without a core. One transfer is outstanding at a time. Wait states are honoured, and a programmable timeout bounds a transfer that never sees PREADY.

## Interface
- APB_ADDR_WIDTH, 12, width of PADDR and req_addr
- TIMEOUT_CYCLES, 255, max ACCESS wait cycles with PREADY low before abort; 0 disables the timeout
- HCLK  in  1  clock; all logic on rising edge
- HRESETn  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_addr  in  APB_ADDR_WIDTH  byte address
- req_wdata  in  32  write data
- req_write  in  1  1 = write, 0 = read
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_rdata  out  32  read data; 0 for writes and for aborted transfers
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1 (0 while HRESETn low).
  - On handshake: register addr, wdata and write into PADDR, PWDATA and PWRITE, then go to SETUP.
- SETUP: PSEL = 1, PENABLE = 0. Unconditionally go to ACCESS; clear the wait counter.
- ACCESS: PSEL = 1, PENABLE = 1.
  - PREADY = 1: capture PRDATA (reads only; writes capture 0) and PSLVERR into rsp_err. Set rsp_timeout = 0. Go to RESP.
  - PREADY = 0: increment the wait counter. If the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES ≠ 0), abort: rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1, go to RESP.
- RESP:
  - PSEL = PENABLE = 0 and rsp_valid = 1.
  - Response fields are held stable until the rsp_ready handshake, then go to IDLE.
- PADDR, PWDATA and PWRITE are held stable from SETUP to the end of ACCESS. They keep their last value in IDLE and RESP.
- PSLVERR is sampled only in the ACCESS cycle where PREADY = 1.
- Wait counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- The response path is not allowed to block APB: a transfer in ACCESS always completes, and any backpressure is absorbed in RESP.

## Timing
- Reset (HRESETn low at an edge): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA all 0; rsp_valid, rsp_err, rsp_timeout 0; rsp_rdata 0.
- Reset mid-transfer: the transfer is dropped with no response. PSEL and PENABLE are 0 from the next edge.
- Zero-wait latency: request handshake at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2 → rsp_valid in cycle 3.
- Each PREADY-low cycle adds 1 cycle of latency.
- Throughput: with zero waits and rsp_ready tied high, one transfer per 4 cycles. The request that follows a response handshake is accepted in the next IDLE cycle.
- A timeout abort asserts rsp_valid exactly TIMEOUT_CYCLES+1 cycles after SETUP.
- rsp_ready held high while rsp_valid is low has no effect.

## Structure
- Package apb_acc_pkg:
  - apb_state_e enum.
  - Accelerator register byte offsets: ACC_REG_0..ACC_REG_4 = 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014.
  - Default TIMEOUT_CYCLES constant.
- Sub-module apb_wait_timer (clear, count enable, expired flag) is natural. Everything else lives in the top-level FSM.

## Test plan
- Write 0x04030201 to 0x004, PREADY = 1:
  - Cycle 1: PSEL = 1, PENABLE = 0, PADDR = 0x004, PWRITE = 1, PWDATA = 0x04030201.
  - Cycle 2: PENABLE = 1.
  - Cycle 3: rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
- Read 0x008, PREADY low for 3 ACCESS cycles, then high with PRDATA = 0x00020001:
  - PENABLE high for 4 cycles with PADDR and PWRITE stable.
  - rsp_rdata = 0x00020001, rsp_err = 0.
- Read 0x018, PREADY = 1 and PSLVERR = 1 → rsp_err = 1, rsp_timeout = 0.
- TIMEOUT_CYCLES = 8, PREADY stuck low:
  - Abort after 8 wait cycles; PSEL drops.
  - rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- Hold rsp_ready low for 5 cycles with req_valid high:
  - rsp fields stable, req_ready = 0, no new SETUP.
  - Next transfer SETUP occurs 2 cycles after the handshake.
- HRESETn low for 1 cycle during ACCESS:
  - Next edge PSEL = PENABLE = 0; no rsp_valid.
  - After release, req_ready = 1 and a new request completes normally.
